// File: rtl/par_check_ser.sv
// rtl/par_check_ser.sv - bit-serial UART RX parity checker with sticky flag and saturating error counter
module par_check_ser #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 par_en,
    input  logic [1:0]           par_typ,
    input  logic                 bit_valid,
    input  logic                 sampled_bit,
    input  logic                 clr_err,
    output logic                 par_done,
    output logic                 par_err,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t               state, state_n;
    logic                 acc, acc_n;
    logic [BW-1:0]        cnt, cnt_n;
    logic                 en_q, en_n;
    logic [1:0]           typ_q, typ_n;
    logic                 done_n, err_n, sticky_n;
    logic [CNT_WIDTH-1:0] ecnt_n;
    logic                 expected;
    logic                 bad;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            en_q       <= 1'b0;
            typ_q      <= 2'b00;
            par_done   <= 1'b0;
            par_err    <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            cnt        <= cnt_n;
            en_q       <= en_n;
            typ_q      <= typ_n;
            par_done   <= done_n;
            par_err    <= err_n;
            err_sticky <= sticky_n;
            err_cnt    <= ecnt_n;
        end
    end

    // Parity bit the frame should carry, from the mode latched at start.
    always_comb begin
        expected = 1'b0;
        case (typ_q)
            2'b00:   expected = acc;
            2'b01:   expected = ~acc;
            2'b10:   expected = 1'b1;
            default: expected = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        en_n    = en_q;
        typ_n   = typ_q;
        done_n  = 1'b0;
        err_n   = par_err;
        bad     = 1'b0;

        if (start) begin
            state_n = DATA;
            acc_n   = 1'b0;
            cnt_n   = '0;
            en_n    = par_en;
            typ_n   = par_typ;
        end else if (bit_valid) begin
            case (state)
                DATA: begin
                    acc_n = acc ^ sampled_bit;
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST) begin
                        if (en_q) begin
                            state_n = PARITY;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            err_n   = 1'b0;
                        end
                    end
                end
                PARITY: begin
                    bad     = (sampled_bit != expected);
                    err_n   = bad;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: ;
            endcase
        end

        // Clear takes effect before a same-edge error is counted.
        sticky_n = clr_err ? 1'b0 : err_sticky;
        ecnt_n   = clr_err ? '0 : err_cnt;
        if (bad) begin
            sticky_n = 1'b1;
            if (ecnt_n != '1) begin
                ecnt_n = ecnt_n + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_par_check_ser.sv
// tb/tb_par_check_ser.sv - randomized self-checking bench for par_check_ser
module tb_par_check_ser;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start, par_en, bit_valid, sampled_bit, clr_err;
    logic [1:0] par_typ;
    logic       par_done, par_err, err_sticky;
    logic [7:0] err_cnt;
    logic       par_done2, par_err2, err_sticky2;
    logic [1:0] err_cnt2;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt8 = 0;
    int exp_cnt2 = 0;
    bit exp_sticky = 0;
    bit exp_err    = 0;

    par_check_ser #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .par_en(par_en), .par_typ(par_typ),
        .bit_valid(bit_valid), .sampled_bit(sampled_bit), .clr_err(clr_err),
        .par_done(par_done), .par_err(par_err), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    par_check_ser #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .CLK(CLK), .RST(RST), .start(start), .par_en(par_en), .par_typ(par_typ),
        .bit_valid(bit_valid), .sampled_bit(sampled_bit), .clr_err(clr_err),
        .par_done(par_done2), .par_err(par_err2), .err_sticky(err_sticky2), .err_cnt(err_cnt2)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        par_en      = 1'b0;
        par_typ     = 2'b00;
        bit_valid   = 1'b0;
        sampled_bit = 1'b0;
        clr_err     = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        n_checks++;
        if (err_sticky !== exp_sticky) $display("FAIL %s err_sticky: got %b want %b", tag, err_sticky, exp_sticky);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 8'(exp_cnt8)) $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, exp_cnt8);
        else n_pass++;
        n_checks++;
        if (err_cnt2 !== 2'(exp_cnt2) || err_sticky2 !== exp_sticky)
            $display("FAIL %s sat err_cnt/sticky: got %0d/%b want %0d/%b", tag, err_cnt2, err_sticky2, exp_cnt2, exp_sticky);
        else n_pass++;
    endtask

    // Drives one frame with random gaps and mid-frame mode noise; model derives the result from popcount.
    task automatic send_frame(input logic [7:0] data, input bit en, input logic [1:0] typ,
                              input bit pbit, input bit clr, input string tag);
        int         spurious = 0;
        int         total;
        int         ones;
        bit         want_bit;
        bit         err;
        logic [8:0] bits;
        bits        = {pbit, data};
        total       = en ? 9 : 8;
        start       = 1'b1;
        par_en      = en;
        par_typ     = typ;
        bit_valid   = 1'($urandom_range(0, 1));
        sampled_bit = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        for (int i = 0; i < total; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bit_valid = 1'b0;
                par_en    = 1'($urandom_range(0, 1));
                par_typ   = 2'($urandom_range(0, 3));
                tick();
                if (par_done) spurious++;
            end
            bit_valid   = 1'b1;
            sampled_bit = bits[i];
            if (i == total - 1) clr_err = clr;
            tick();
            if (i < total - 1 && par_done) spurious++;
        end
        clr_err = 1'b0;

        ones = $countones(data);
        case (typ)
            2'b00:   want_bit = ones[0];
            2'b01:   want_bit = !ones[0];
            2'b10:   want_bit = 1'b1;
            default: want_bit = 1'b0;
        endcase
        err = en && (pbit != want_bit);
        if (clr) begin
            exp_cnt8   = 0;
            exp_cnt2   = 0;
            exp_sticky = 0;
        end
        if (err) begin
            exp_sticky = 1;
            exp_cnt8   = (exp_cnt8 < 255) ? exp_cnt8 + 1 : 255;
            exp_cnt2   = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
        end
        exp_err = err;

        n_checks++;
        if (spurious !== 0) $display("FAIL %s early par_done: got %0d pulses want 0", tag, spurious);
        else n_pass++;
        n_checks++;
        if (par_done !== 1'b1) $display("FAIL %s par_done: got %b want 1", tag, par_done);
        else n_pass++;
        n_checks++;
        if (par_err !== exp_err) $display("FAIL %s par_err: got %b want %b", tag, par_err, exp_err);
        else n_pass++;
        check_counters(tag);

        // A stray bit after the frame must be ignored in IDLE.
        bit_valid   = 1'b1;
        sampled_bit = 1'($urandom_range(0, 1));
        tick();
        bit_valid = 1'b0;
        n_checks++;
        if (par_done !== 1'b0 || par_err !== exp_err)
            $display("FAIL %s after-frame done/err: got %b/%b want 0/%b", tag, par_done, par_err, exp_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b0;
        #12;
        n_checks++;
        if ({par_done, par_err, err_sticky, err_cnt, err_cnt2} !== 13'd0)
            $display("FAIL reset outputs: got %b/%b/%b/%0d/%0d want all 0", par_done, par_err, err_sticky, err_cnt, err_cnt2);
        else n_pass++;
        RST = 1'b1;
        tick();
    endtask

    task automatic test_even();
        send_frame(8'hA5, 1, 2'b00, 1'b0, 0, "even_ok");
        send_frame(8'hA5, 1, 2'b00, 1'b1, 0, "even_bad");
    endtask

    task automatic test_modes();
        send_frame(8'h01, 1, 2'b01, 1'b0, 0, "odd_ok");
        send_frame(8'h00, 1, 2'b10, 1'b0, 0, "mark_bad");
        send_frame(8'h5A, 1, 2'b11, 1'b0, 0, "space_ok");
    endtask

    task automatic test_no_parity();
        send_frame(8'h3C, 0, 2'b10, 1'b0, 0, "no_parity");
    endtask

    task automatic test_abort();
        int spurious = 0;
        start   = 1'b1;
        par_en  = 1'b1;
        par_typ = 2'b01;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid   = 1'b1;
            sampled_bit = 1'($urandom_range(0, 1));
            tick();
            if (par_done) spurious++;
        end
        bit_valid = 1'b0;
        n_checks++;
        if (spurious !== 0) $display("FAIL abort partial par_done: got %0d want 0", spurious);
        else n_pass++;
        send_frame(8'hFF, 1, 2'b00, 1'b0, 0, "abort_restart");
    endtask

    task automatic test_clear();
        clr_err = 1'b1;
        tick();
        clr_err    = 1'b0;
        exp_cnt8   = 0;
        exp_cnt2   = 0;
        exp_sticky = 0;
        check_counters("clr_alone");
        n_checks++;
        if (par_err !== exp_err) $display("FAIL clr_alone par_err: got %b want %b", par_err, exp_err);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) send_frame(8'h00, 1, 2'b10, 1'b0, 0, "sat_bad");
        send_frame(8'h00, 1, 2'b10, 1'b0, 1, "sat_clr_same_edge");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            send_frame(8'($urandom), $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, "random");
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h00, 1, 2'b10, 1'b0, 0, "pre_reset_bad");
        start   = 1'b1;
        par_en  = 1'b1;
        par_typ = 2'b00;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid   = 1'b1;
            sampled_bit = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        exp_cnt8   = 0;
        exp_cnt2   = 0;
        exp_sticky = 0;
        exp_err    = 0;
        n_checks++;
        if ({par_done, par_err, err_sticky, err_cnt, err_cnt2} !== 13'd0)
            $display("FAIL async reset mid-frame: got %b/%b/%b/%0d/%0d want all 0", par_done, par_err, err_sticky, err_cnt, err_cnt2);
        else n_pass++;
        #2;
        RST = 1'b1;
        tick();
        send_frame(8'h81, 1, 2'b01, 1'b1, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_even();
        test_modes();
        test_no_parity();
        test_abort();
        test_clear();
        test_saturation();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
